// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the RV32I core. Watches decode, execute and
// memory and produces the hold / bubble / flush controls for the pipeline
// latches. Hazards resolve in fixed priority: memory wait, taken jump, load-use.
// A taken jump starts a flush sequence lasting FLUSH_CYCLES unstalled cycles.
//
// Optional feature macro: HAZARD_CTRL_PERF_EN
//   defined   -> STALL_CNT / FLUSH_CNT are live 32-bit wrapping counters
//   undefined -> both ports are tied to zero and no counter flops exist
//
// Parameters:
//   FLUSH_CYCLES  unstalled cycles FLUSH stays high after a taken jump (1..7)
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   D_VALID/D_OPCODE     decode-stage valid and opcode
//   D_REG_S1/D_REG_S2    decode-stage source register indices
//   E_VALID/E_OPCODE     execute-stage valid and opcode
//   E_REG_D              execute-stage destination register index
//   E_JMP_DO             execute resolved a taken branch/JAL/JALR
//   M_BUSY               memory stage waiting on the data bus
//   STALL                hold every latch (including writeback)
//   HOLD_FD              hold PC, fetch and decode latches (load-use)
//   BUBBLE_E             execute latch captures an invalid instruction
//   FLUSH                F->D and D->E latches capture invalid
//   STALL_CNT            cycles with STALL or HOLD_FD high
//   FLUSH_CNT            number of accepted taken-jump flush events
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        D_VALID,
  input  logic [6:0]  D_OPCODE,
  input  logic [4:0]  D_REG_S1,
  input  logic [4:0]  D_REG_S2,
  input  logic        E_VALID,
  input  logic [6:0]  E_OPCODE,
  input  logic [4:0]  E_REG_D,
  input  logic        E_JMP_DO,
  input  logic        M_BUSY,
  output logic        STALL,
  output logic        HOLD_FD,
  output logic        BUBBLE_E,
  output logic        FLUSH,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  // The first flush cycle happens in RUN; FLUSHING covers the remainder.
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 32'd1);
  localparam logic [2:0] FCNT_INIT   = 3'(FLUSH_CYCLES - 32'd1);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_FLUSHING = 1'b1
  } state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_fcnt;
  logic [2:0] w_next_fcnt;
  logic       w_jmp;
  logic       w_lu;
  logic       w_stall;
  logic       w_hold;
  logic       w_bubble;
  logic       w_flush;

  assign w_jmp = E_VALID & E_JMP_DO;

  // x0 never matches because E_REG_D must be non-zero.
  assign w_lu = D_VALID & E_VALID & (E_OPCODE == OP_LOAD) & (E_REG_D != 5'd0) &
                ((uses_rs1(D_OPCODE) & (D_REG_S1 == E_REG_D)) |
                 (uses_rs2(D_OPCODE) & (D_REG_S2 == E_REG_D)));

  // Next-state and Mealy control decode in priority order.
  always_comb begin
    w_next_state = r_state;
    w_next_fcnt  = r_fcnt;
    w_stall      = 1'b0;
    w_hold       = 1'b0;
    w_bubble     = 1'b0;
    w_flush      = 1'b0;
    if (M_BUSY) begin
      // Memory wait freezes the flush sequence; execute is held so jmp persists.
      w_stall = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_jmp) begin
            // Decode holds a wrong-path instruction, so load-use is moot.
            w_flush = 1'b1;
            if (MULTI_FLUSH) begin
              w_next_state = ST_FLUSHING;
              w_next_fcnt  = FCNT_INIT;
            end else begin
              w_next_state = ST_RUN;
              w_next_fcnt  = 3'd0;
            end
          end else if (w_lu) begin
            w_hold   = 1'b1;
            w_bubble = 1'b1;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_FLUSHING: begin
          w_flush = 1'b1;
          if (r_fcnt <= 3'd1) begin
            w_next_state = ST_RUN;
            w_next_fcnt  = 3'd0;
          end else begin
            w_next_fcnt = r_fcnt - 3'd1;
          end
        end
        default: begin
          w_next_state = ST_RUN;
          w_next_fcnt  = 3'd0;
        end
      endcase
    end
  end

  // Flush state register and remaining-cycle counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_RUN;
      r_fcnt  <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_fcnt  <= w_next_fcnt;
    end
  end

  // Reset masks the Mealy controls so no hold/flush escapes during reset.
  assign STALL    = w_stall;
  assign HOLD_FD  = w_hold & RST_N;
  assign BUBBLE_E = w_bubble & RST_N;
  assign FLUSH    = w_flush & RST_N;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_accept_jmp;

  assign w_accept_jmp = ~M_BUSY & (r_state == ST_RUN) & w_jmp;

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_stall | w_hold) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_accept_jmp) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;
`else
  assign STALL_CNT = 32'h0;
  assign FLUSH_CNT = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES = 2).
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] RTYP  = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_valid = 1'b0, e_valid = 1'b0, e_jmp_do = 1'b0, m_busy = 1'b0;
  logic [6:0]  d_opcode = 7'd0, e_opcode = 7'd0;
  logic [4:0]  d_reg_s1 = 5'd0, d_reg_s2 = 5'd0, e_reg_d = 5'd0;
  logic        stall, hold_fd, bubble_e, flush;
  logic [31:0] stall_cnt, flush_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_scnt = 32'd0;
  logic [31:0] m_fcnt = 32'd0;
  logic [3:0]  exp_q[$];   // {STALL, HOLD_FD, BUBBLE_E, FLUSH}

  typedef struct packed {
    logic       dv;  logic [6:0] dop; logic [4:0] s1; logic [4:0] s2;
    logic       ev;  logic [6:0] eop; logic [4:0] rd;
    logic       jd;  logic       mb;  logic       acc; logic [3:0] exp;
  } stim_t;

  hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .CLK(clk), .RST_N(rst_n),
    .D_VALID(d_valid), .D_OPCODE(d_opcode), .D_REG_S1(d_reg_s1), .D_REG_S2(d_reg_s2),
    .E_VALID(e_valid), .E_OPCODE(e_opcode), .E_REG_D(e_reg_d), .E_JMP_DO(e_jmp_do),
    .M_BUSY(m_busy),
    .STALL(stall), .HOLD_FD(hold_fd), .BUBBLE_E(bubble_e), .FLUSH(flush),
    .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic dv, input logic [6:0] dop, input logic [4:0] s1,
                               input logic [4:0] s2, input logic ev, input logic [6:0] eop,
                               input logic [4:0] rd, input logic jd, input logic mb,
                               input logic acc, input logic [3:0] exp);
    stim_t s;
    s.dv = dv; s.dop = dop; s.s1 = s1; s.s2 = s2; s.ev = ev; s.eop = eop; s.rd = rd;
    s.jd = jd; s.mb = mb; s.acc = acc; s.exp = exp;
    return s;
  endfunction

  // Drive one cycle of stimulus and push its expected controls to the scoreboard.
  task automatic apply(input stim_t s);
    d_valid = s.dv; d_opcode = s.dop; d_reg_s1 = s.s1; d_reg_s2 = s.s2;
    e_valid = s.ev; e_opcode = s.eop; e_reg_d = s.rd; e_jmp_do = s.jd; m_busy = s.mb;
    exp_q.push_back(s.exp);
    if (rst_n) begin
      if (s.exp[3] | s.exp[2]) m_scnt = m_scnt + 32'd1;
      if (s.acc) m_fcnt = m_fcnt + 32'd1;
    end
  endtask

  stim_t idle;

  task automatic test_reset();
    logic [3:0] got, exp;
    // In reset with a load-use and jump pattern and M_BUSY: only STALL may show.
    apply(mk(1'b1, RTYP, 5'd5, 5'd7, 1'b1, LOAD, 5'd5, 1'b1, 1'b1, 1'b0, 4'b1000));
    #1;
    got = {stall, hold_fd, bubble_e, flush}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL reset_busy: ctrl got %b expected %b", got, exp); end
    apply(mk(1'b1, RTYP, 5'd5, 5'd7, 1'b1, LOAD, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0000));
    #1;
    got = {stall, hold_fd, bubble_e, flush}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL reset_mask: ctrl got %b expected %b", got, exp); end
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk); apply(idle); rst_n = 1'b1;
    void'(exp_q.pop_front());
  endtask

  task automatic test_load_use();
    stim_t seq[4];
    logic [3:0] got, exp;
    seq[0] = mk(1'b1, RTYP,  5'd5, 5'd7, 1'b1, LOAD, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0110); // add x6,x5,x7
    seq[1] = mk(1'b1, RTYP,  5'd5, 5'd7, 1'b0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000); // load advanced
    seq[2] = mk(1'b1, STORE, 5'd1, 5'd9, 1'b1, LOAD, 5'd9, 1'b0, 1'b0, 1'b0, 4'b0110); // rs2 of store
    seq[3] = idle;
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]); #1;
      got = {stall, hold_fd, bubble_e, flush}; exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL load_use[%0d]: ctrl got %b expected %b", i, got, exp); end
    end
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== (PERF ? m_scnt : 32'd0)) begin
      n_errors++; $display("FAIL load_use_cnt: STALL_CNT got %0d expected %0d", stall_cnt, PERF ? m_scnt : 32'd0);
    end
  endtask

  task automatic test_no_false();
    stim_t seq[6];
    logic [3:0] got, exp;
    seq[0] = mk(1'b1, RTYP,  5'd0, 5'd0, 1'b1, LOAD, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000); // load to x0
    seq[1] = mk(1'b1, LUI,   5'd5, 5'd0, 1'b1, LOAD, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0000); // lui field=5
    seq[2] = mk(1'b1, OPIMM, 5'd2, 5'd5, 1'b1, LOAD, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0000); // addi rs2 field=5
    seq[3] = mk(1'b0, RTYP,  5'd5, 5'd7, 1'b1, LOAD, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0000); // decode invalid
    seq[4] = mk(1'b1, RTYP,  5'd5, 5'd7, 1'b1, RTYP, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0000); // not a load
    seq[5] = idle;
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]); #1;
      got = {stall, hold_fd, bubble_e, flush}; exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL no_false[%0d]: ctrl got %b expected %b", i, got, exp); end
    end
  endtask

  task automatic test_jump();
    stim_t seq[3];
    logic [3:0] got, exp;
    seq[0] = mk(1'b0, 7'd0, 5'd0, 5'd0, 1'b1, RTYP, 5'd0, 1'b1, 1'b0, 1'b1, 4'b0001);
    seq[1] = mk(1'b0, 7'd0, 5'd0, 5'd0, 1'b1, RTYP, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0001); // ignored jmp
    seq[2] = idle;
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]); #1;
      got = {stall, hold_fd, bubble_e, flush}; exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL jump[%0d]: ctrl got %b expected %b", i, got, exp); end
    end
    @(negedge clk);
    n_checks++;
    if (flush_cnt !== (PERF ? m_fcnt : 32'd0)) begin
      n_errors++; $display("FAIL jump_cnt: FLUSH_CNT got %0d expected %0d", flush_cnt, PERF ? m_fcnt : 32'd0);
    end
  endtask

  task automatic test_busy_flush();
    stim_t seq[10];
    logic [3:0] got, exp;
    seq[0] = mk(1'b0, 7'd0, 5'd0, 5'd0, 1'b1, RTYP, 5'd0, 1'b1, 1'b0, 1'b1, 4'b0001);
    for (int k = 1; k <= 3; k++)
      seq[k] = mk(1'b0, 7'd0, 5'd0, 5'd0, 1'b1, RTYP, 5'd0, 1'b1, 1'b1, 1'b0, 4'b1000);
    seq[4] = mk(1'b0, 7'd0, 5'd0, 5'd0, 1'b0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0001); // remaining flush
    seq[5] = idle;
    // Busy in RUN with a pending jump: the jump waits until M_BUSY drops.
    seq[6] = mk(1'b0, 7'd0, 5'd0, 5'd0, 1'b1, RTYP, 5'd0, 1'b1, 1'b1, 1'b0, 4'b1000);
    seq[7] = mk(1'b0, 7'd0, 5'd0, 5'd0, 1'b1, RTYP, 5'd0, 1'b1, 1'b0, 1'b1, 4'b0001);
    seq[8] = mk(1'b0, 7'd0, 5'd0, 5'd0, 1'b0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0001);
    seq[9] = idle;
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]); #1;
      got = {stall, hold_fd, bubble_e, flush}; exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL busy_flush[%0d]: ctrl got %b expected %b", i, got, exp); end
    end
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== (PERF ? m_scnt : 32'd0) || flush_cnt !== (PERF ? m_fcnt : 32'd0)) begin
      n_errors++;
      $display("FAIL busy_flush_cnt: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt,
               PERF ? m_scnt : 32'd0, PERF ? m_fcnt : 32'd0);
    end
  endtask

  task automatic test_jump_lu();
    stim_t seq[3];
    logic [3:0] got, exp;
    seq[0] = mk(1'b1, RTYP, 5'd5, 5'd7, 1'b1, LOAD, 5'd5, 1'b1, 1'b0, 1'b1, 4'b0001);
    seq[1] = mk(1'b1, RTYP, 5'd5, 5'd7, 1'b1, LOAD, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0001); // lu ignored
    seq[2] = idle;
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]); #1;
      got = {stall, hold_fd, bubble_e, flush}; exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL jump_lu[%0d]: ctrl got %b expected %b", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [3:0] got, exp;
    @(negedge clk);
    apply(mk(1'b0, 7'd0, 5'd0, 5'd0, 1'b1, RTYP, 5'd0, 1'b1, 1'b0, 1'b1, 4'b0001));
    #1;
    got = {stall, hold_fd, bubble_e, flush}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL rmf_jump: ctrl got %b expected %b", got, exp); end
    @(negedge clk);                     // now in FLUSHING
    apply(idle); exp_q.pop_back();
    rst_n = 1'b0; m_scnt = 32'd0; m_fcnt = 32'd0;
    exp_q.push_back(4'b0000);
    #1;
    got = {stall, hold_fd, bubble_e, flush}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL rmf_drop: ctrl got %b expected %b", got, exp); end
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_errors++; $display("FAIL rmf_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); apply(idle); #1;    // must be RUN, so no residual flush
    got = {stall, hold_fd, bubble_e, flush}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL rmf_run: ctrl got %b expected %b", got, exp); end
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_errors++; $display("FAIL rmf_cnt_after: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    idle = mk(1'b0, 7'd0, 5'd0, 5'd0, 1'b0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    test_reset();
    test_load_use();
    test_no_false();
    test_jump();
    test_busy_flush();
    test_jump_lu();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the RV32I core.
- Watches the decode, execute and memory stages and drives the hold, bubble and flush controls that sequence the fetch, decode, execute and memory latches.
- Resolves three hazards in fixed priority: memory wait, taken jump/branch, load-use.
- Keeps a small flush state machine so that in-flight wrong-path instructions are squashed over several cycles.

## Interface
- `FLUSH_CYCLES`, default 2: number of unstalled cycles `FLUSH` stays high after a taken jump (legal range 1–7).
- `CLK` in 1: clock. All state updates on rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `D_VALID` in 1: decode stage holds a valid instruction.
- `D_OPCODE` in 7: decode-stage opcode.
- `D_REG_S1` in 5: decode-stage rs1 index.
- `D_REG_S2` in 5: decode-stage rs2 index.
- `E_VALID` in 1: execute stage holds a valid instruction.
- `E_OPCODE` in 7: execute-stage opcode.
- `E_REG_D` in 5: execute-stage rd index.
- `E_JMP_DO` in 1: execute resolved a taken branch, JAL or JALR this cycle.
- `M_BUSY` in 1: memory stage waiting on the data bus.
- `STALL` out 1: hold every pipeline latch, including register-file writeback.
- `HOLD_FD` out 1: hold the PC, fetch and decode latches for a load-use stall.
- `BUBBLE_E` out 1: execute latch captures an invalid instruction (`valid=0`).
- `FLUSH` out 1: fetch→decode and decode→execute latches capture invalid.
- `STALL_CNT` out 32: cycles with `STALL` or `HOLD_FD` high.
- `FLUSH_CNT` out 32: number of taken-jump flush events.

## Operation
- **rs1 usage:** rs1 is read by every opcode except LUI `0110111`, AUIPC `0010111` and JAL `1101111`.
- **rs2 usage:** rs2 is read only by R-type `0110011`, store `0100011` and branch `1100011`.
- **x0:** index 0 never creates a hazard.
- **Load-use hazard (`lu`):** all of the following hold:
  - `D_VALID` and `E_VALID`;
  - `E_OPCODE == 0000011`;
  - `E_REG_D != 0`;
  - `E_REG_D` equals a used rs1 or a used rs2.
- **`jmp`:** `E_VALID & E_JMP_DO`.
- **State machine:** two states, `RUN` and `FLUSHING`, plus a 3-bit counter `fcnt`.
- **Priority 1, memory wait:** `M_BUSY=1` → `STALL=1`, every other control output 0. State and `fcnt` are frozen.
- **Priority 2, taken jump (RUN, `jmp`):**
  - `FLUSH=1` this cycle.
  - If `FLUSH_CYCLES > 1`: go to `FLUSHING` with `fcnt = FLUSH_CYCLES-1`.
  - Otherwise stay in `RUN`.
  - `lu` is ignored, since the instruction in decode is wrong-path.
- **FLUSHING:**
  - `FLUSH=1` every unstalled cycle; `fcnt` decrements.
  - When `fcnt==1` at the edge, return to `RUN`.
  - `jmp` and `lu` are ignored while in `FLUSHING`.
- **Priority 3, load-use (RUN, `lu`):** `HOLD_FD=1` and `BUBBLE_E=1` for exactly one cycle. The next cycle the load has advanced, so `lu` re-evaluates to 0.
- **Otherwise:** all control outputs 0.
- **Exclusivity:** `HOLD_FD` and `FLUSH` are never high together. `STALL` excludes all other controls.

## Timing
- **Reset** (`RST_N` low, asynchronous; takes effect immediately, including mid-flush):
  - state `RUN`, `fcnt=0`;
  - `STALL_CNT=0`, `FLUSH_CNT=0`.
- **Output timing:** control outputs are combinational from state and current inputs (Mealy), so a hazard is acted on in the same cycle it is seen.
  - During reset, `HOLD_FD`, `BUBBLE_E` and `FLUSH` are 0.
  - `STALL` follows `M_BUSY`.
- **Latency:** load-use costs one cycle. A taken jump costs `FLUSH_CYCLES` unstalled cycles.
- **Simultaneous events:**
  - `M_BUSY` with `jmp`: the jump is not taken into account until `M_BUSY` falls. The execute latch is held, so `jmp` persists.
  - `jmp` with `lu`: the flush wins.
- **Counters:**
  - `STALL_CNT` increments on every edge where `STALL|HOLD_FD`.
  - `FLUSH_CNT` increments on the edge that accepts `jmp` in `RUN`.
  - Both wrap modulo 2^32.

## Configuration
- **`HAZARD_CTRL_PERF_EN` defined:** `STALL_CNT` and `FLUSH_CNT` are implemented as described above.
- **`HAZARD_CTRL_PERF_EN` undefined:** both ports are tied to 32'h0 and no counter flops are built. All control behaviour is identical.

## Test plan
- **Load-use hazard:** execute holds `lw x5` (`E_OPCODE=0000011`, `E_REG_D=5`); decode holds `add x6,x5,x7`.
  - → `HOLD_FD=BUBBLE_E=1` for 1 cycle, then 0.
  - → `STALL_CNT` goes 0→1.
- **No false hazards:**
  - Load to x0 with decode rs1=0 → no hold.
  - Load x5 with decode `lui x5` (rs1 field=5) → no hold.
  - Load x5 with decode `addi x1,x2,5` (rs2 field=5) → no hold.
- **Taken jump:** `jmp` pulse with `FLUSH_CYCLES=2` → `FLUSH` high for 2 consecutive cycles, `FLUSH_CNT=1`. A second `jmp` during the 2nd cycle is ignored.
- **Memory wait during flush:** `M_BUSY=1` for 3 cycles in the middle of `FLUSHING` → `STALL=1` and `FLUSH=0` for those 3 cycles; the remaining flush cycle follows afterwards.
- **Simultaneous jump and load-use:** `jmp` and `lu` in the same cycle → `FLUSH=1`, `HOLD_FD=0`.
- **Reset mid-flush:** `RST_N` low during `FLUSHING` → `FLUSH` drops immediately. After release, state is `RUN` and counters read 0; with the macro undefined, the counters read 0 always.
